// File: rtl/rvh_pmp_chk_arb.sv
// Round-robin arbiter for the shared PMP check port. It holds off checks while PMP CSR writes settle.
// Define RVH_PMP_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority, where the lowest index wins.
module rvh_pmp_chk_arb #(
  parameter int REQ_COUNT    = 3,
  parameter int FENCE_CYCLES = 1,
  parameter int PADDR_WIDTH  = 56
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [REQ_COUNT-1:0]             req_vld_i,
  output logic [REQ_COUNT-1:0]             req_rdy_o,
  input  logic [REQ_COUNT*PADDR_WIDTH-1:0] req_paddr_i,
  input  logic [REQ_COUNT*2-1:0]           req_access_type_i,
  input  logic [REQ_COUNT*2-1:0]           req_priv_lvl_i,
  input  logic                             csr_pmp_wr_i,
  output logic                             pmp_check_vld_o,
  output logic [PADDR_WIDTH-1:0]           pmp_check_paddr_o,
  output logic [1:0]                       pmp_check_access_type_o,
  output logic [1:0]                       pmp_priv_lvl_o,
  input  logic                             pmp_check_fail_i,
  output logic [REQ_COUNT-1:0]             resp_vld_o,
  output logic                             resp_fail_o
);

  localparam int PTR_W = $clog2(REQ_COUNT);
  localparam int CNT_W = (FENCE_CYCLES > 0) ? $clog2(FENCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FENCE_CYCLES);
  localparam logic [PTR_W:0]   REQ_NUM  = (PTR_W + 1)'(REQ_COUNT);

  typedef enum logic {ST_RUN, ST_BLOCK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             grant_en;
  logic             grant;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic             win_found;
  logic [PTR_W:0]   search_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (csr_pmp_wr_i && (FENCE_CYCLES > 0)) begin
          state_nxt = ST_BLOCK;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ST_BLOCK: begin
        if (csr_pmp_wr_i) begin
          cnt_nxt = CNT_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The write cycle itself never grants, so the new PMP config is never checked half-written.
  always_comb begin
    grant_en = rstn && (state == ST_RUN) && !csr_pmp_wr_i;
  end

  always_comb begin
    win        = '0;
    win_found  = 1'b0;
    search_idx = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      search_idx = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (search_idx >= REQ_NUM) search_idx = search_idx - REQ_NUM;
      if (!win_found && req_vld_i[search_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win       = search_idx[PTR_W-1:0];
      end
    end
  end

  assign grant = grant_en && win_found;

  always_comb begin
    req_rdy_o               = '0;
    pmp_check_vld_o         = 1'b0;
    pmp_check_paddr_o       = '0;
    pmp_check_access_type_o = '0;
    pmp_priv_lvl_o          = '0;
    if (grant) begin
      req_rdy_o[win]          = 1'b1;
      pmp_check_vld_o         = 1'b1;
      pmp_check_paddr_o       = req_paddr_i[int'(win)*PADDR_WIDTH +: PADDR_WIDTH];
      pmp_check_access_type_o = req_access_type_i[int'(win)*2 +: 2];
      pmp_priv_lvl_o          = req_priv_lvl_i[int'(win)*2 +: 2];
    end
  end

`ifdef RVH_PMP_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (win == PTR_W'(REQ_COUNT - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

  // The response cannot be back-pressured. The PMP result is captured in the grant cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_vld_o  <= '0;
      resp_fail_o <= 1'b0;
    end else begin
      resp_vld_o  <= grant ? req_rdy_o : '0;
      resp_fail_o <= grant && pmp_check_fail_i;
    end
  end

endmodule

// File: tb/tb_rvh_pmp_chk_arb.sv
// Bench for rvh_pmp_chk_arb. It checks the outputs against a cycle-count based arbitration model.
module tb_rvh_pmp_chk_arb;
  localparam int R  = 3;
  localparam int FC = 2;
  localparam int PA = 40;
  localparam int CW = R + 1 + PA + 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [R-1:0]    vld = '0;
  logic [R-1:0]    rdy;
  logic [R*PA-1:0] paddr = '0;
  logic [2*R-1:0]  at = '0;
  logic [2*R-1:0]  pv = '0;
  logic            csr = 1'b0;
  logic            cv;
  logic [PA-1:0]   cpa;
  logic [1:0]      cat;
  logic [1:0]      cpv;
  logic            fail = 1'b0;
  logic [R-1:0]    rvld;
  logic            rfail;

  int tests = 0;
  int fails = 0;

  // Model state: blocking is tracked as "no grant up to and including cycle m_block_until".
  int           cyc = 0;
  int           m_ptr = 0;
  int           m_block_until = -1;
  logic [R-1:0] m_rvld = '0;
  logic         m_rfail = 1'b0;

  always #5 clk = ~clk;

  rvh_pmp_chk_arb #(.REQ_COUNT(R), .FENCE_CYCLES(FC), .PADDR_WIDTH(PA)) dut (
    .clk(clk), .rstn(rstn),
    .req_vld_i(vld), .req_rdy_o(rdy), .req_paddr_i(paddr),
    .req_access_type_i(at), .req_priv_lvl_i(pv),
    .csr_pmp_wr_i(csr),
    .pmp_check_vld_o(cv), .pmp_check_paddr_o(cpa),
    .pmp_check_access_type_o(cat), .pmp_priv_lvl_o(cpv),
    .pmp_check_fail_i(fail),
    .resp_vld_o(rvld), .resp_fail_o(rfail)
  );

  function automatic int model_winner();
    int p;
`ifdef RVH_PMP_ARB_FIXED_PRIO_EN
    p = 0;
`else
    p = m_ptr;
`endif
    if (!rstn || csr || cyc <= m_block_until) return -1;
    for (int k = 0; k < R; k++) begin
      if (vld[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] exp_comb();
    int w;
    logic [R-1:0] oh;
    w = model_winner();
    if (w < 0) return '0;
    oh = '0;
    oh[w] = 1'b1;
    return {oh, 1'b1, paddr[w*PA +: PA], at[w*2 +: 2], pv[w*2 +: 2]};
  endfunction

  task automatic drive(input logic [R-1:0] v, input logic c, input logic f);
    vld  = v;
    csr  = c;
    fail = f;
    for (int i = 0; i < R; i++) paddr[i*PA +: PA] = PA'({$urandom(), $urandom()});
    at = 6'($urandom());
    pv = 6'($urandom());
  endtask

  task automatic tick();
    int w;
    logic [R-1:0] oh;
    w = model_winner();
    oh = '0;
    if (!rstn) begin
      m_rvld  = '0;
      m_rfail = 1'b0;
    end else if (w >= 0) begin
      oh[w]   = 1'b1;
      m_rvld  = oh;
      m_rfail = fail;
      m_ptr   = (w + 1) % R;
    end else begin
      m_rvld  = '0;
      m_rfail = 1'b0;
    end
    if (rstn && csr) m_block_until = cyc + FC;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive('1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #4;
      tests++;
      if ({rdy, cv, cpa, cat, cpv} !== exp_comb()) begin
        fails++;
        $display("FAIL reset_comb cyc %0d: got %h want %h", cyc, {rdy, cv, cpa, cat, cpv}, exp_comb());
      end
      tests++;
      if ({rvld, rfail} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_resp cyc %0d: got %b want 0000", cyc, {rvld, rfail});
      end
      tick();
    end
    rstn = 1'b1;
    m_ptr = 0;
    m_block_until = -1;
    drive('0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_round_robin();
    logic [R-1:0] want;
    for (int k = 0; k < 7; k++) begin
      drive((k < 6) ? 3'b111 : 3'b000, 1'b0, 1'($urandom()));
      #4;
`ifdef RVH_PMP_ARB_FIXED_PRIO_EN
      want = (k < 6) ? 3'b001 : 3'b000;
`else
      want = (k < 6) ? (3'b001 << (k % 3)) : 3'b000;
`endif
      tests++;
      if (rdy !== want) begin
        fails++;
        $display("FAIL rr_order k %0d: got %b want %b", k, rdy, want);
      end
      tests++;
      if ({rdy, cv, cpa, cat, cpv} !== exp_comb()) begin
        fails++;
        $display("FAIL rr_comb cyc %0d: got %h want %h", cyc, {rdy, cv, cpa, cat, cpv}, exp_comb());
      end
      tests++;
      if ({rvld, rfail} !== {m_rvld, m_rfail}) begin
        fails++;
        $display("FAIL rr_resp cyc %0d: got %b want %b", cyc, {rvld, rfail}, {m_rvld, m_rfail});
      end
      tick();
    end
  endtask

  task automatic test_single_fail();
    drive(3'b010, 1'b0, 1'b1);
    paddr[PA +: PA] = PA'(32'h8000_0000);
    #4;
    tests++;
    if (cv !== 1'b1 || cpa !== PA'(32'h8000_0000)) begin
      fails++;
      $display("FAIL single_drive: got vld %b paddr %h want 1 8000_0000", cv, cpa);
    end
    tick();
    drive(3'b000, 1'b0, 1'b0);
    #4;
    tests++;
    if (rvld !== 3'b010 || rfail !== 1'b1) begin
      fails++;
      $display("FAIL single_resp: got %b/%b want 010/1", rvld, rfail);
    end
    tick();
  endtask

  task automatic test_fence(input int nwr);
    for (int k = 0; k < nwr + FC + 2; k++) begin
      drive(3'b111, (k < nwr), 1'($urandom()));
      #4;
      tests++;
      if ((k < nwr + FC) ? (rdy !== 3'b000) : (k == nwr + FC && rdy === 3'b000)) begin
        fails++;
        $display("FAIL fence_gate nwr %0d k %0d: got rdy %b", nwr, k, rdy);
      end
      tests++;
      if ({rdy, cv, cpa, cat, cpv} !== exp_comb()) begin
        fails++;
        $display("FAIL fence_comb cyc %0d: got %h want %h", cyc, {rdy, cv, cpa, cat, cpv}, exp_comb());
      end
      tests++;
      if ({rvld, rfail} !== {m_rvld, m_rfail}) begin
        fails++;
        $display("FAIL fence_resp cyc %0d: got %b want %b", cyc, {rvld, rfail}, {m_rvld, m_rfail});
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    drive(3'b001, 1'b0, 1'b1);
    #4;
    tests++;
    if (rdy !== 3'b001) begin
      fails++;
      $display("FAIL midrst_grant: got %b want 001", rdy);
    end
    tick();
    rstn = 1'b0;
    m_rvld = '0;
    m_rfail = 1'b0;
    m_ptr = 0;
    m_block_until = -1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) rstn = 1'b1;
      drive((k == 3) ? 3'b000 : 3'b111, 1'b0, 1'b1);
      #4;
      if (k == 4) begin
        tests++;
        if (rdy !== 3'b001) begin
          fails++;
          $display("FAIL midrst_ptr: got %b want 001", rdy);
        end
      end
      tests++;
      if ({rdy, cv, cpa, cat, cpv} !== exp_comb()) begin
        fails++;
        $display("FAIL midrst_comb cyc %0d: got %h want %h", cyc, {rdy, cv, cpa, cat, cpv}, exp_comb());
      end
      tests++;
      if ({rvld, rfail} !== {m_rvld, m_rfail}) begin
        fails++;
        $display("FAIL midrst_resp cyc %0d: got %b want %b", cyc, {rvld, rfail}, {m_rvld, m_rfail});
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), 1'($urandom()));
      #4;
      tests++;
      if ({rdy, cv, cpa, cat, cpv} !== exp_comb()) begin
        fails++;
        $display("FAIL rand_comb cyc %0d: got %h want %h", cyc, {rdy, cv, cpa, cat, cpv}, exp_comb());
      end
      tests++;
      if ({rvld, rfail} !== {m_rvld, m_rfail}) begin
        fails++;
        $display("FAIL rand_resp cyc %0d: got %b want %b", cyc, {rvld, rfail}, {m_rvld, m_rfail});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_fail();
    test_fence(1);
    test_fence(2);
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rvh_pmp_chk_arb.md
# rvh_pmp_chk_arb

Arbiter and sequencer for the shared PMP permission-check port. It accepts physical-address check requests from up to REQ_COUNT requesters (e.g. ITLB, DTLB, PTW) and grants one per cycle, round-robin. It drives the PMP check inputs combinationally from the winner and returns a registered pass/fail response to the winner one cycle later. It also holds off all checks while pmpcfg/pmpaddr CSR writes settle.

## Interface
Parameters:
- REQ_COUNT, 3: number of requesters, 2..8.
- FENCE_CYCLES, 1: cycles checks stay blocked after the last CSR PMP write, 0..15.
- PADDR_WIDTH: project-wide physical address width from the shared params header.

Ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  asynchronous active-low reset.
- req_vld_i  in  REQ_COUNT  per-requester check request valid.
- req_rdy_o  out  REQ_COUNT  per-requester grant/ready, at most one bit set.
- req_paddr_i  in  REQ_COUNT*PADDR_WIDTH  packed addresses; requester i at bits [i*PADDR_WIDTH +: PADDR_WIDTH].
- req_access_type_i  in  REQ_COUNT*2  packed access type (PMP encoding).
- req_priv_lvl_i  in  REQ_COUNT*2  packed effective privilege (0=U, 1=S, 3=M).
- csr_pmp_wr_i  in  1  a pmpcfg or pmpaddr write is committed this cycle.
- pmp_check_vld_o  out  1  drive to PMP check valid.
- pmp_check_paddr_o  out  PADDR_WIDTH  winner address.
- pmp_check_access_type_o  out  2  winner access type.
- pmp_priv_lvl_o  out  2  winner privilege.
- pmp_check_fail_i  in  1  PMP result, combinational in the same cycle.
- resp_vld_o  out  REQ_COUNT  one-hot response valid.
- resp_fail_o  out  1  access fault for the responding requester.

## Operation
- FSM has two states:
  - RUN: grants allowed.
  - BLOCK: no grants; a down-counter cnt runs.
- Grant exists in cycle T iff state==RUN, csr_pmp_wr_i==0 and |req_vld_i. The winner is the first set req_vld_i bit searched from ptr upward, wrapping at REQ_COUNT.
- req_rdy_o[w]=1 only for the winner w. It depends combinationally on req_vld_i; requesters must not derive vld from rdy.
- Handshake is req_vld_i[w]&req_rdy_o[w]. On a handshake, ptr<=(w+1) mod REQ_COUNT. Otherwise ptr holds.
- PMP drive:
  - pmp_check_vld_o = grant.
  - pmp_check_paddr_o, pmp_check_access_type_o and pmp_priv_lvl_o = winner fields.
  - All four outputs are zero when there is no grant.
- Response register:
  - resp_vld_o <= one-hot(w) on grant, else 0.
  - resp_fail_o <= pmp_check_fail_i on grant, else 0.
  - Requesters cannot back-pressure the response.
- CSR fence:
  - csr_pmp_wr_i=1 blocks the grant in the same cycle.
  - If FENCE_CYCLES>0: state<=BLOCK, cnt<=FENCE_CYCLES.
  - In BLOCK: cnt decrements each cycle. When cnt==1 and csr_pmp_wr_i==0, state<=RUN. A write while in BLOCK reloads cnt.
  - If FENCE_CYCLES==0: only the write cycle is blocked and BLOCK is never entered.
- cnt width is clog2(FENCE_CYCLES+1). Minimum width is 1.

## Timing
- Reset values: state=RUN, ptr=0, cnt=0, resp_vld_o=0, resp_fail_o=0.
- While rstn=0: req_rdy_o=0 and pmp_check_vld_o=0.
- Grant and PMP drive happen in cycle T. The response is visible at T+1.
- Sustained throughput is one check per cycle.
- A write at T with FENCE_CYCLES=N blocks cycles T..T+N. The first grant can occur at T+N+1.
- The response to a grant issued before a write is still delivered at T+1, using the pre-write configuration.
- Reset asserted mid-operation: any pending response is dropped. No resp_vld_o is produced after rstn deasserts.

## Configuration
- RVH_PMP_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. ptr is not implemented and is treated as 0.
  - Undefined (default): round-robin as described above.

## Test plan
- REQ_COUNT=3, all vld held high for 6 cycles, no CSR write -> grants 0,1,2,0,1,2; resp_vld_o = 001,010,100,... each delayed by one cycle.
- Single requester 1, paddr=0x8000_0000, pmp_check_fail_i=1 -> pmp_check_paddr_o=0x8000_0000 at T; resp_vld_o=010 and resp_fail_o=1 at T+1.
- FENCE_CYCLES=2, csr_pmp_wr_i pulse at T with requests pending -> req_rdy_o=0 at T,T+1,T+2; first grant at T+3.
- FENCE_CYCLES=2, second csr_pmp_wr_i at T+1 -> cnt reloads; first grant at T+4.
- rstn pulled low the cycle after a grant -> resp_vld_o=0 throughout reset and after; ptr restarts at 0.
- With RVH_PMP_ARB_FIXED_PRIO_EN defined, vld=111 held -> requester 0 granted every cycle; requesters 1 and 2 starve.
